// File: rtl/param_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : param_alu_pkg
//  Description : Shared types for the serial-command ALU. Holds the FSM state
//                encoding and the 3-bit opcode encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package param_alu_pkg;

    localparam int c_OP_BITS = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP1  = 3'd1,
        ST_OP2  = 3'd2,
        ST_EXEC = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_PAR  = 3'b101,
        OP_COMP = 3'b110,
        OP_SHL  = 3'b111
    } opcode_e;

endpackage
`default_nettype wire

// File: rtl/param_alu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : param_alu_datapath
//  Description : Operand/opcode capture registers, combinational op unit and
//                registered result/overflow for the serial-command ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_alu_datapath
    import param_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_BITS    = c_OP_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_a,
    input  logic                  cap_b,
    input  logic                  shift_op,
    input  logic                  exec,
    input  logic                  opcode,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    localparam int                    c_SHW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_ONE = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [OP_BITS-1:0]      r_op;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_overflow;

    logic [DATA_WIDTH:0]     w_sum;
    logic [2*DATA_WIDTH-1:0] w_shl_wide;
    logic [DATA_WIDTH-1:0]   w_res;
    logic                    w_ovf;

    // Carry-extended sum and a double-width shift so shifted-out bits stay visible
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_shl_wide = {{DATA_WIDTH{1'b0}}, r_a} << r_b[c_SHW-1:0];

    // Opcode bits arrive LSB first, so they shift in from the top of r_op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (cap_a)    r_a  <= data;
            if (cap_b)    r_b  <= data;
            if (shift_op) r_op <= {opcode, r_op[OP_BITS-1:1]};
            if (exec) begin
                r_result   <= w_res;
                r_overflow <= w_ovf;
            end
        end
    end

    // Operation unit: evaluates the captured command
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (opcode_e'(r_op))
            OP_ADD: begin
                w_res = w_sum[DATA_WIDTH-1:0];
                w_ovf = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                w_res = r_a - r_b;
                w_ovf = (r_a < r_b);
            end
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_PAR:  w_res = {{(DATA_WIDTH-1){1'b0}}, ^{r_a, r_b}};
            OP_COMP: begin
                if (r_a > r_b)      w_res = c_ONE;
                else if (r_a < r_b) w_res = '1;
                else                w_res = '0;
            end
            OP_SHL: begin
                w_res = w_shl_wide[DATA_WIDTH-1:0];
                w_ovf = |w_shl_wide[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            default: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    assign result   = r_result;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/param_alu.sv
`default_nettype none
// ============================================================================
//  Module      : param_alu
//  Description : Serial-command ALU. A frame of OP_BITS cycles delivers the
//                opcode LSB first together with operands A and B; the result
//                is presented with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_alu
    import param_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_BITS    = c_OP_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  opcode_valid,
    input  logic                  opcode,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    state_e                r_state;
    state_e                w_next_state;
    logic                  w_cap_a;
    logic                  w_cap_b;
    logic                  w_shift_op;
    logic                  w_exec;
    logic [DATA_WIDTH-1:0] w_dp_result;
    logic                  w_dp_overflow;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Frame sequencing; opcode_valid is ignored in EXEC and DONE
    always_comb begin
        w_next_state = r_state;
        w_cap_a      = 1'b0;
        w_cap_b      = 1'b0;
        w_shift_op   = 1'b0;
        w_exec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (opcode_valid) begin
                    w_cap_a      = 1'b1;
                    w_shift_op   = 1'b1;
                    w_next_state = ST_OP1;
                end
            end
            ST_OP1: begin
                if (opcode_valid) begin
                    w_cap_b      = 1'b1;
                    w_shift_op   = 1'b1;
                    w_next_state = ST_OP2;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_OP2: begin
                if (opcode_valid) begin
                    w_shift_op   = 1'b1;
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_exec       = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    param_alu_datapath #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_BITS    (OP_BITS)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .cap_a    (w_cap_a),
        .cap_b    (w_cap_b),
        .shift_op (w_shift_op),
        .exec     (w_exec),
        .opcode   (opcode),
        .data     (data),
        .result   (w_dp_result),
        .overflow (w_dp_overflow)
    );

    // Outputs are only exposed during the DONE cycle
    assign busy     = (r_state == ST_OP1) || (r_state == ST_OP2) ||
                      (r_state == ST_EXEC) || (r_state == ST_DONE);
    assign done     = (r_state == ST_DONE);
    assign result   = done ? w_dp_result : '0;
    assign overflow = done ? w_dp_overflow : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_param_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_alu
//  Description : Self-checking bench for param_alu (DATA_WIDTH=8) with an
//                arithmetic reference model and randomized frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_alu;

    logic       clk;
    logic       reset;
    logic       opcode_valid;
    logic       opcode;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    param_alu #(
        .DATA_WIDTH (8),
        .OP_BITS    (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_valid (opcode_valid),
        .opcode       (opcode),
        .data         (data),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model from the arithmetic definitions: returns {overflow, result}
    function automatic logic [8:0] model(input logic [2:0] op, input int a, input int b);
        int   r;
        logic v;
        r = 0;
        v = 1'b0;
        case (op)
            3'd0: begin r = a + b; v = (r > 255); r = r % 256; end
            3'd1: begin r = a - b; v = (a < b); if (r < 0) r = r + 256; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($countones(a) + $countones(b)) % 2;
            3'd6: r = (a > b) ? 1 : ((a == b) ? 0 : 255);
            default: begin r = a * (2 ** (b % 8)); v = (r > 255); r = r % 256; end
        endcase
        return {v, r[7:0]};
    endfunction

    // Drives one frame starting at a negedge in IDLE; always returns at a negedge in IDLE.
    // cut: 0 full, 2 drop valid in OP1, 3 drop valid in OP2, 4 reset in EXEC, 5 reset in DONE
    task automatic frame(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int cut);
        logic [8:0] exp;
        exp = model(op, int'(a), int'(b));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        opcode_valid = 1'b1; opcode = op[0]; data = a;
        @(negedge clk);
        check("op1_busy", 32'(busy), 32'd1);
        check("op1_done", 32'(done), 32'd0);
        check("op1_result", 32'(result), 32'd0);
        if (cut == 2) begin
            opcode_valid = 1'b0; data = 8'($urandom);
            repeat (3) begin
                @(negedge clk);
                check("abort1_done", 32'(done), 32'd0);
                check("abort1_busy", 32'(busy), 32'd0);
            end
            return;
        end
        opcode = op[1]; data = b;
        @(negedge clk);
        check("op2_busy", 32'(busy), 32'd1);
        check("op2_done", 32'(done), 32'd0);
        if (cut == 3) begin
            opcode_valid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("abort2_done", 32'(done), 32'd0);
                check("abort2_busy", 32'(busy), 32'd0);
            end
            return;
        end
        opcode = op[2]; data = 8'($urandom);
        @(negedge clk);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_done", 32'(done), 32'd0);
        check("exec_result", 32'(result), 32'd0);
        check("exec_ovf", 32'(overflow), 32'd0);
        if (cut == 4) begin
            reset = 1'b1;
            #1;
            check("rst_exec_busy", 32'(busy), 32'd0);
            check("rst_exec_done", 32'(done), 32'd0);
            @(negedge clk);
            check("rst_exec_hold_done", 32'(done), 32'd0);
            check("rst_exec_hold_res", 32'(result), 32'd0);
            reset = 1'b0; opcode_valid = 1'b0;
            return;
        end
        opcode_valid = 1'($urandom_range(0, 1)); opcode = 1'($urandom); data = 8'($urandom);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_result", 32'(result), 32'(exp[7:0]));
        check("done_ovf", 32'(overflow), 32'(exp[8]));
        if (cut == 5) begin
            reset = 1'b1;
            #1;
            check("rst_done_done", 32'(done), 32'd0);
            check("rst_done_result", 32'(result), 32'd0);
            check("rst_done_busy", 32'(busy), 32'd0);
            @(negedge clk);
            reset = 1'b0; opcode_valid = 1'b0;
            return;
        end
        opcode_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; opcode_valid = 1'b0; opcode = 1'b0; data = 8'h00;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed frames, back-to-back from the first edge after reset
        frame(3'b000, 8'hF0, 8'h20, 0);
        frame(3'b001, 8'h05, 8'h07, 0);
        frame(3'b110, 8'h05, 8'h07, 0);
        frame(3'b110, 8'h07, 8'h05, 0);
        frame(3'b110, 8'h33, 8'h33, 0);
        frame(3'b111, 8'h81, 8'h09, 0);
        frame(3'b111, 8'h01, 8'h07, 0);
        frame(3'b101, 8'h03, 8'h01, 0);
        frame(3'b000, 8'h12, 8'h34, 0);
        frame(3'b011, 8'hA0, 8'h05, 0);

        // Aborted frames followed by full ones
        frame(3'b100, 8'hAA, 8'h0F, 3);
        frame(3'b100, 8'hAA, 8'h0F, 0);
        frame(3'b000, 8'hFF, 8'hFF, 2);
        frame(3'b001, 8'h10, 8'h01, 0);

        // Reset mid-command, then immediate new frames
        frame(3'b000, 8'hFF, 8'h01, 4);
        frame(3'b010, 8'hFF, 8'h3C, 0);
        frame(3'b111, 8'hFF, 8'h04, 5);
        frame(3'b001, 8'h00, 8'h01, 0);

        // Randomized back-to-back frames
        for (int i = 0; i < 60; i++) begin
            frame(3'($urandom), 8'($urandom), 8'($urandom), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 Parameter: DATA_WIDTH, 8, operand/result width in bits; legal range 4..32.
REQ-002 Parameter: OP_BITS, 3, serial opcode length in bits; fixed at 3 for this generation.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: opcode_valid  input  1  high for OP_BITS consecutive cycles to frame one command.
REQ-006 Port: opcode  input  1  serial opcode bit, LSB first, sampled while opcode_valid=1.
REQ-007 Port: data  input  DATA_WIDTH  operand bus; A sampled on frame cycle 0, B on frame cycle 1.
REQ-008 Port: busy  output  1  high from frame cycle 1 through DONE inclusive.
REQ-009 Port: done  output  1  one-cycle pulse marking result/overflow valid.
REQ-010 Port: result  output  DATA_WIDTH  operation result, valid when done=1, else 0.
REQ-011 Port: overflow  output  1  operation overflow flag, valid when done=1, else 0.

Function
REQ-012 FSM states SHALL be IDLE, OP1, OP2, EXEC, DONE; encoded states not listed SHALL return to IDLE.
REQ-013 IDLE with opcode_valid=1: capture opcode bit0 and A=data, go OP1; else stay IDLE.
REQ-014 OP1 with opcode_valid=1: capture bit1 and B=data, go OP2; opcode_valid=0: abort to IDLE, no done.
REQ-015 OP2 with opcode_valid=1: capture bit2, go EXEC; opcode_valid=0: abort to IDLE, no done.
REQ-016 EXEC SHALL compute and register result/overflow in one cycle, then go DONE unconditionally.
REQ-017 DONE SHALL assert done=1 for exactly one cycle, then go IDLE; opcode_valid in EXEC/DONE SHALL be ignored.
REQ-018 Latency: done SHALL rise exactly 2 cycles after the cycle carrying opcode bit2; a new frame may start the cycle after DONE.
REQ-019 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PAR, 110 COMP, 111 SHL.
REQ-020 ADD: result=(A+B) mod 2^W; overflow=unsigned carry-out.
REQ-021 SUB: result=(A-B) mod 2^W; overflow=1 iff A<B (unsigned borrow).
REQ-022 AND/OR/XOR: bitwise; overflow=0.
REQ-023 PAR: result=zero-extended XOR-reduction of {A,B}; overflow=0.
REQ-024 COMP (unsigned): result=1 if A>B, 0 if A==B, all-ones if A<B; overflow=0.
REQ-025 SHL: result=A shifted left by B[clog2(W)-1:0]; overflow=1 iff any 1 bit shifted out; upper B bits ignored.
REQ-026 result and overflow SHALL be 0 in every state except DONE.

Reset
REQ-027 Reset assertion SHALL immediately force state IDLE, busy=0, done=0, result=0, overflow=0, captured opcode/A/B=0.
REQ-028 Reset mid-frame or mid-EXEC SHALL discard the command; no done pulse after release.
REQ-029 First frame SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-030 Package param_alu_pkg SHALL hold the state enum and 3-bit opcode enum/constants.
REQ-031 Sub-module param_alu_datapath (parametrised DATA_WIDTH) SHALL hold A/B/opcode registers and the combinational op unit; FSM stays in param_alu.

Verification (DATA_WIDTH=8)
REQ-032 ADD 0xF0+0x20 -> done 2 cycles after bit2, result=0x10, overflow=1, busy high OP1..DONE.
REQ-033 SUB 0x05-0x07 -> result=0xFE, overflow=1; COMP 0x05 vs 0x07 -> result=0xFF, overflow=0.
REQ-034 SHL A=0x81, B=0x09 (shift 1) -> result=0x02, overflow=1; PAR A=0x03,B=0x01 -> result=0x01.
REQ-035 opcode_valid dropped in OP2 -> no done, FSM IDLE; next full XOR 0xAA^0x0F -> result=0xA5.
REQ-036 reset pulsed in EXEC -> no done, all outputs 0; following AND 0xFF&0x3C -> result=0x3C.
REQ-037 Back-to-back frames starting cycle after DONE -> two done pulses, each correct, none dropped.
